// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter and its FIFO.
package rf_writeback_arbiter_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_W        = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // Which producer owns the write port this cycle.
    typedef enum logic {
        PIPE_PRI = 1'b0,
        LU_PRI   = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// Small synchronous FIFO of {rd, data} for long-latency results.
// The head is read combinationally so a pop can write it the same cycle.
module wb_fifo
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REG_W-1:0] push_rd,
    input  logic [XLEN-1:0]  push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [REG_W-1:0] head_rd,
    output logic [XLEN-1:0]  head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [REG_W-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_rd   = rd_mem[rd_ptr_reg[AW-1:0]];
    assign head_data = data_mem[rd_ptr_reg[AW-1:0]];

    // Pointer advance; reset empties the FIFO so stale entries are never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Entry storage; contents need no reset because the pointers gate validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            rd_mem[wr_ptr_reg[AW-1:0]]   <= push_rd;
            data_mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the single
// register-file write port, with starvation protection and an ID-read bypass.
module rf_writeback_arbiter
    import rf_writeback_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_valid,
    input  logic [REG_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]  pipe_data,
    output logic             stall_req,
    input  logic             lu_valid,
    output logic             lu_ready,
    input  logic [REG_W-1:0] lu_rd,
    input  logic [XLEN-1:0]  lu_data,
    output logic             rd_en,
    output logic [REG_W-1:0] rd,
    output logic [XLEN-1:0]  rd_datain,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             rs1_fwd,
    output logic             rs2_fwd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             pending
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [REG_W-1:0] head_rd;
    logic [XLEN-1:0]  head_data;

    wb_sel_e          sel_state;
    logic             sel_valid;
    logic [REG_W-1:0] sel_rd;
    logic [XLEN-1:0]  sel_data;

    logic [CW-1:0]    starve_cnt_reg;
    logic [CW-1:0]    starve_cnt_next;
    logic             rd_en_reg;
    logic [REG_W-1:0] rd_reg;
    logic [XLEN-1:0]  rd_datain_reg;

    wb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_rd   (lu_rd),
        .push_data (lu_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_rd   (head_rd),
        .head_data (head_data)
    );

    // Space is judged before any same-cycle pop, so a pop never frees room early.
    assign lu_ready  = !fifo_full;
    assign fifo_push = lu_valid && !fifo_full;
    assign pending   = !fifo_empty;
    assign stall_req = pending && (starve_cnt_reg == STARVE_LIM);

    // Choose the write-port owner: starved FIFO head, then pipeline, then idle drain.
    always_comb begin
        sel_state = PIPE_PRI;
        if (stall_req || (!pipe_valid && pending)) begin
            sel_state = LU_PRI;
        end
        fifo_pop  = (sel_state == LU_PRI);
        sel_valid = (sel_state == LU_PRI) || pipe_valid;
        sel_rd    = (sel_state == LU_PRI) ? head_rd   : pipe_rd;
        sel_data  = (sel_state == LU_PRI) ? head_data : pipe_data;
    end

    // Count pipeline wins while the FIFO waits; any pop or an empty FIFO clears it.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (fifo_pop || !pending) begin
            starve_cnt_next = '0;
        end else if (pipe_valid && (starve_cnt_reg < STARVE_LIM)) begin
            starve_cnt_next = starve_cnt_reg + CNT_ONE;
        end
    end

    // Starvation counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Registered write port; writes to x0 are consumed but never enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_reg     <= 1'b0;
            rd_reg        <= REG_ZERO;
            rd_datain_reg <= '0;
        end else begin
            rd_en_reg <= sel_valid && (sel_rd != REG_ZERO);
            if (sel_valid) begin
                rd_reg        <= sel_rd;
                rd_datain_reg <= sel_data;
            end
        end
    end

    assign rd        = rd_reg;
    assign rd_en     = rd_en_reg;
    assign rd_datain = rd_datain_reg;
    assign fwd_data  = rd_datain_reg;
    assign rs1_fwd   = rd_en_reg && (rd_reg != REG_ZERO) && (rd_reg == rs1);
    assign rs2_fwd   = rd_en_reg && (rd_reg != REG_ZERO) && (rd_reg == rs2);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized and directed bench for rf_writeback_arbiter against a queue model.
module tb_rf_writeback_arbiter;

    localparam int XLEN       = 32;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pipe_valid = 1'b0;
    logic [4:0]      pipe_rd = '0;
    logic [XLEN-1:0] pipe_data = '0;
    logic            stall_req;
    logic            lu_valid = 1'b0;
    logic            lu_ready;
    logic [4:0]      lu_rd = '0;
    logic [XLEN-1:0] lu_data = '0;
    logic            rd_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_datain;
    logic [4:0]      rs1 = '0;
    logic [4:0]      rs2 = '0;
    logic            rs1_fwd;
    logic            rs2_fwd;
    logic [XLEN-1:0] fwd_data;
    logic            pending;

    rf_writeback_arbiter #(
        .XLEN       (XLEN),
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .stall_req  (stall_req),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .rd_en      (rd_en),
        .rd         (rd),
        .rd_datain  (rd_datain),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_fwd    (rs1_fwd),
        .rs2_fwd    (rs2_fwd),
        .fwd_data   (fwd_data),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    // Reference model: FIFO as a queue, waiting time as a plain integer.
    ent_t            m_q[$];
    int              m_starve;
    logic            m_rd_en;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_rd_en  = 1'b0;
        m_rd     = '0;
        m_data   = '0;
    endtask

    // One clock of the model, from the rules: who writes, what gets queued,
    // how long the queue head has been waiting.
    task automatic model_step();
        int   occ;
        bit   starving;
        bit   wrote;
        bit   popped;
        ent_t w;
        occ      = m_q.size();
        starving = (occ > 0) && (m_starve == STARVE_MAX);
        wrote    = 1'b0;
        popped   = 1'b0;
        w        = '0;
        if (starving) begin
            w = m_q.pop_front(); wrote = 1'b1; popped = 1'b1;
        end else if (pipe_valid) begin
            w.rd = pipe_rd; w.data = pipe_data; wrote = 1'b1;
        end else if (occ > 0) begin
            w = m_q.pop_front(); wrote = 1'b1; popped = 1'b1;
        end
        if (lu_valid && (occ < DEPTH)) begin
            ent_t e;
            e.rd = lu_rd; e.data = lu_data;
            m_q.push_back(e);
        end
        if (popped || occ == 0) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
        m_rd_en = wrote && (w.rd != 5'd0);
        if (wrote) begin
            m_rd   = w.rd;
            m_data = w.data;
        end
    endtask

    // Compare process: every falling edge, every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk1("rd_en", rd_en, m_rd_en);
            if (m_rd_en) begin
                chk32("rd", 32'(rd), 32'(m_rd));
                chk32("rd_datain", rd_datain, m_data);
                chk32("fwd_data", fwd_data, m_data);
                $display("WR rd=%0d data=0x%08h t=%0t", m_rd, m_data, $time);
            end
            chk1("lu_ready", lu_ready, m_q.size() < DEPTH);
            chk1("pending", pending, m_q.size() != 0);
            chk1("stall_req", stall_req, (m_q.size() != 0) && (m_starve == STARVE_MAX));
            chk1("rs1_fwd", rs1_fwd, m_rd_en && (m_rd != 5'd0) && (m_rd == rs1));
            chk1("rs2_fwd", rs2_fwd, m_rd_en && (m_rd != 5'd0) && (m_rd == rs2));
        end
    end

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] r1, input logic [4:0] r2);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
        rs1 = r1; rs2 = r2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        model_reset();
        idle();
        cmp_en = 1'b1;

        // Reset held three cycles, then idle.
        rst = 1'b1;
        repeat (3) cycle();
        chk1("rst_rd_en", rd_en, 1'b0);
        chk1("rst_lu_ready", lu_ready, 1'b1);
        rst = 1'b0;
        repeat (3) begin
            cycle();
            chk1("idle_rd_en", rd_en, 1'b0);
            chk1("idle_stall", stall_req, 1'b0);
            chk1("idle_pending", pending, 1'b0);
        end

        // Pipe write and bypass.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
        #1;
        chk1("pw_rd_en", rd_en, 1'b1);
        chk32("pw_rd", 32'(rd), 32'd5);
        chk32("pw_data", rd_datain, 32'hDEADBEEF);
        chk1("pw_rs1_fwd", rs1_fwd, 1'b1);
        chk1("pw_rs2_fwd", rs2_fwd, 1'b0);
        chk32("pw_fwd_data", fwd_data, 32'hDEADBEEF);
        cycle();

        // LU fill under continuous pipeline writes, until starvation.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'(k + 1), 32'(100 + k), (k < 2), 5'(7 + k), 32'(7 + k), 5'd0, 5'd0);
            cycle();
            if (k == 1) chk1("fill_lu_ready", lu_ready, 1'b0);
            if (k == 3) chk1("fill_no_stall_yet", stall_req, 1'b0);
        end
        chk1("fill_stall", stall_req, 1'b1);
        drive(1'b1, 5'd6, 32'd105, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle();
        chk32("starve_rd", 32'(rd), 32'd7);
        chk32("starve_data", rd_datain, 32'd7);
        chk1("starve_rd_en", rd_en, 1'b1);
        idle();
        cycle();
        chk32("starve_next_rd", 32'(rd), 32'd8);
        cycle();

        // Idle drain of two pending entries.
        drive(1'b1, 5'd1, 32'd11, 1'b1, 5'd7, 32'd7, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd2, 32'd12, 1'b1, 5'd8, 32'd8, 5'd0, 5'd0);
        cycle();
        idle();
        cycle();
        chk32("drain_rd7", 32'(rd), 32'd7);
        chk1("drain_pending_mid", pending, 1'b1);
        cycle();
        chk32("drain_rd8", 32'(rd), 32'd8);
        chk1("drain_pending_end", pending, 1'b0);
        cycle();

        // x0 suppression.
        drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
        cycle();
        chk1("x0_pipe_rd_en", rd_en, 1'b0);
        chk1("x0_rs1_fwd", rs1_fwd, 1'b0);
        chk1("x0_pending", pending, 1'b1);
        idle();
        cycle();
        chk1("x0_lu_rd_en", rd_en, 1'b0);
        chk1("x0_consumed", pending, 1'b0);

        // Asynchronous reset with two entries pending.
        drive(1'b1, 5'd1, 32'd21, 1'b1, 5'd7, 32'd7, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd2, 32'd22, 1'b1, 5'd8, 32'd8, 5'd0, 5'd0);
        cycle();
        idle();
        chk1("ar_pending_before", pending, 1'b1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk1("ar_rd_en", rd_en, 1'b0);
        chk1("ar_pending", pending, 1'b0);
        chk1("ar_lu_ready", lu_ready, 1'b1);
        repeat (2) cycle();
        rst = 1'b0;
        repeat (4) begin
            cycle();
            chk1("ar_no_write", rd_en, 1'b0);
        end

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r1;
            logic [4:0] r2;
            r1 = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom_range(0, 31));
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom(),
                  r1, r2);
            cycle();
        end

        idle();
        cycle();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side counterpart of the ID-stage register file. Merges two result producers into the single register-file write port (rd_en / rd / rd_datain):
  - the in-order pipeline writeback, single-cycle and never buffered;
  - a long-latency unit (divider/load miss) using a valid/ready handshake, buffered in a small FIFO.
- Registers the write port outputs.
- Provides a bypass for ID-stage reads that collide with the write issued in the same cycle.

Parameters:
- XLEN, 32, data width
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, cycles a non-empty FIFO head may wait before pipeline writeback is stalled

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pipe_valid  in  1  pipeline writeback present
- pipe_rd  in  5  pipeline destination
- pipe_data  in  XLEN  pipeline result
- stall_req  out  1  pipeline writeback not accepted this cycle; upstream holds and re-presents
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept
- lu_rd  in  5  long-latency destination
- lu_data  in  XLEN  long-latency result
- rd_en  out  1  register-file write enable
- rd  out  5  register-file write address
- rd_datain  out  XLEN  register-file write data
- rs1  in  5  ID read address 1
- rs2  in  5  ID read address 2
- rs1_fwd  out  1  rs1 matches write in flight
- rs2_fwd  out  1  rs2 matches write in flight
- fwd_data  out  XLEN  equals rd_datain, for the bypass mux
- pending  out  1  FIFO non-empty

Behaviour:
- Reset (async, rst=1): rd_en=0, rd=0, rd_datain=0, FIFO empty, starve_cnt=0.
  - Resulting outputs: lu_ready=1, stall_req=0, pending=0.
  - Mid-operation reset discards all FIFO contents; no write is issued for them.
- FIFO push:
  - Push when lu_valid && lu_ready.
  - lu_ready = !full, combinational.
  - A same-cycle pop frees no space for that cycle's push.
  - lu_rd==0 entries are still pushed, then dropped at pop (rd_en stays 0).
- Arbitration, evaluated each cycle as a two-state select: PIPE_PRI / LU_PRI.
  - stall_req = pending && (starve_cnt == STARVE_MAX), combinational.
  - If stall_req: pop FIFO head and write it; pipe_valid is ignored that cycle.
  - Else if pipe_valid: write the pipe result; the FIFO holds.
  - Else if pending: pop and write the FIFO head.
  - Else: no write.
- starve_cnt:
  - Increments while pending && a pipe write wins.
  - Clears on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- Output register:
  - The selected write appears on rd_en / rd / rd_datain one cycle after selection.
  - rd_en = selected && sel_rd != 0, so x0 is never written.
- Bypass:
  - rsN_fwd = rd_en && rd != 0 && rd == rsN, combinational from registered outputs.
  - fwd_data = rd_datain.
- Ordering:
  - FIFO entries are written strictly in push order.
  - WAW ordering between FIFO and pipeline for the same rd is the issue scoreboard's responsibility, not this block's.
- Throughput: at most one register-file write per cycle.

Decomposition:
- Shared package: XLEN default, register-index width (5), REG_ZERO constant.
- Sub-module wb_fifo: DEPTH-entry synchronous FIFO of {rd, data}.
  - Signals: push, pop, full, empty, head.
  - Pointer wrap via log2(DEPTH)+1-bit pointers.
- Arbitration, starvation counter, output register and bypass stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst for 3 cycles, then idle.
  - Required: rd_en=0, lu_ready=1, stall_req=0, pending=0 throughout.
- Pipe write:
  - Stimulus: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF at cycle N.
  - Required: rd_en=1, rd=5, rd_datain=0xDEADBEEF at N+1. With rs1=5 at N+1, rs1_fwd=1 and fwd_data=0xDEADBEEF.
- LU fill:
  - Stimulus: pipe_valid held 1 with rd=1..; push two LU results (rd=7 data=7, rd=8 data=8).
  - Required: lu_ready=0 after the second push. stall_req=1 after STARVE_MAX=4 pipe-won cycles. rd=7 written the next cycle, and the pipe result is absent that cycle.
- Idle drain:
  - Stimulus: both FIFO entries pending, pipe idle.
  - Required: writes rd=7 then rd=8 on consecutive cycles; pending falls after the second pop.
- x0 suppression:
  - Stimulus: pipe_rd=0 and lu_rd=0 results.
  - Required: rd_en never asserts; rs1=0 gives rs1_fwd=0; the FIFO entry is consumed.
- Async reset mid-operation:
  - Stimulus: assert rst mid-cycle with 2 FIFO entries pending.
  - Required: outputs clear immediately; no write of rd=7 or rd=8 after rst deasserts.
